// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared FSM state type and SPI sizing constants.
package spi_master_pkg;
  localparam int SPI_DIV_WIDTH = 8;
  localparam int SPI_LANES = 4;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, WAIT_DATA, DONE} state_e;
endpackage

// File: rtl/spi_master_clkgen.sv
// spi_master_clkgen: CPOL=0 SCK divider with one-cycle strobes that mark the upcoming rise/fall edge.
module spi_master_clkgen
  import spi_master_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic [SPI_DIV_WIDTH-1:0] div_i,
  output logic                     sck_o,
  output logic                     rise_o,
  output logic                     fall_o
);
  logic [SPI_DIV_WIDTH-1:0] cnt_q;
  logic sck_q, tick;
  assign tick = en_i && cnt_q == div_i;
  assign rise_o = tick && !sck_q;
  assign fall_o = tick && sck_q;
  assign sck_o = sck_q;
  // Disabling parks SCK low with the phase counter cleared, so every restart begins a full low phase.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (tick) begin
      cnt_q <= '0;
      sck_q <= !sck_q;
    end else begin
      cnt_q <= cnt_q + SPI_DIV_WIDTH'(1);
    end
endmodule

// File: rtl/spi_master_tx_shifter.sv
// spi_master_tx_shifter: FIFO-fed MSB-first SPI transmitter; quad lanes enabled by SPI_MASTER_TX_QUAD_EN.
module spi_master_tx_shifter
  import spi_master_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [SPI_DIV_WIDTH-1:0] clk_div_i,
  input  logic                     en_i,
  input  logic [LEN_WIDTH-1:0]     tx_len_i,
  input  logic                     quad_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic                     spi_clk_o,
  output logic [SPI_LANES-1:0]     sdo_o,
  output logic                     busy_o,
  output logic                     done_o
);
  localparam int WW = $clog2(DATA_WIDTH + 1);
  state_e state_q, state_d;
  logic [SPI_DIV_WIDTH-1:0] div_q, div_d;
  logic [LEN_WIDTH-1:0] bits_q, bits_d, step;
  logic [WW-1:0] wbits_q, wbits_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d, sh_nx;
  logic [SPI_LANES-1:0] lanes;
  logic rise, fall;
  spi_master_clkgen u_clkgen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (state_q == SHIFT || ready_o),
    .div_i  (div_q),
    .sck_o  (spi_clk_o),
    .rise_o (rise),
    .fall_o (fall)
  );
`ifdef SPI_MASTER_TX_QUAD_EN
  logic quad_q;
  logic [3:0] top;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) quad_q <= 1'b0;
    else if (state_q == IDLE && en_i) quad_q <= quad_i;
  assign step = quad_q ? LEN_WIDTH'(4) : LEN_WIDTH'(1);
  assign sh_nx = quad_q ? sh_q << 4 : sh_q << 1;
  assign top = ready_o ? data_i[DATA_WIDTH-1 -: 4] : sh_q[DATA_WIDTH-1 -: 4];
  // A short final nibble keeps its valid bits on the high lanes and zeroes the rest.
  assign lanes = quad_q ? top & (bits_q >= LEN_WIDTH'(4) ? 4'hF : ~(4'hF >> bits_q[1:0])) : {3'b0, top[3]};
`else
  logic unused_quad;
  assign unused_quad = quad_i;
  assign step = LEN_WIDTH'(1);
  assign sh_nx = sh_q << 1;
  assign lanes = {3'b0, ready_o ? data_i[DATA_WIDTH-1] : sh_q[DATA_WIDTH-1]};
`endif
  assign sdo_o = (state_q == SHIFT || ready_o) ? lanes : '0;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  // While a word is popped the divider already runs, so a word boundary adds no SCK gap.
  always_comb begin
    state_d = state_q;
    div_d = div_q;
    bits_d = bits_q;
    wbits_d = wbits_q;
    sh_d = sh_q;
    ready_o = 1'b0;
    case (state_q)
      IDLE: if (en_i) begin
        div_d = clk_div_i;
        bits_d = tx_len_i;
        state_d = tx_len_i != '0 ? LOAD : DONE;
      end
      LOAD, WAIT_DATA: begin
        ready_o = valid_i;
        state_d = valid_i ? SHIFT : WAIT_DATA;
        if (valid_i) begin
          sh_d = data_i;
          wbits_d = WW'(DATA_WIDTH) - (rise ? WW'(step) : '0);
        end
      end
      SHIFT: begin
        if (rise) wbits_d = wbits_q - WW'(step);
        if (fall) begin
          sh_d = sh_nx;
          bits_d = bits_q > step ? bits_q - step : '0;
          state_d = bits_q <= step ? DONE : (wbits_q == '0 ? LOAD : SHIFT);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      div_q <= '0;
      bits_q <= '0;
      wbits_q <= '0;
      sh_q <= '0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      bits_q <= bits_d;
      wbits_q <= wbits_d;
      sh_q <= sh_d;
    end
endmodule

// File: tb/tb_spi_master_tx_shifter.sv
// tb_spi_master_tx_shifter: directed and random transfers scored against a bit-stream model of the SPI output.
module tb_spi_master_tx_shifter;
`ifdef SPI_MASTER_TX_QUAD_EN
  localparam bit QUAD_BUILD = 1'b1;
`else
  localparam bit QUAD_BUILD = 1'b0;
`endif
  logic clk_i = 0, rst_ni = 0, en_i = 0, quad_i = 0, valid_i = 0;
  logic [7:0] clk_div_i = 0;
  logic [15:0] tx_len_i = 0;
  logic [31:0] data_i = 0;
  logic ready_o, spi_clk_o, busy_o, done_o;
  logic [3:0] sdo_o;
  int n_checks = 0, n_pass = 0;
  logic [31:0] fifo[$];
  logic [31:0] words_in[8];
  int hold[8];
  logic [3:0] obs[$];
  logic [3:0] prev_sdo = 0;
  logic prev_sck = 0;
  bit quad_eff = 0, scr = 0;
  int cyc = 0, rises = 0, readies = 0, dones = 0, bad_ready = 0, hi13 = 0, irregular = 0;
  int last_rise = 0, start_cyc = 0, done_cyc = 0, rises_at_done = 0, exp_period = 0;
  int ppw = 32, hold_cnt = 0, seen_readies = 0;

  always #5 clk_i = ~clk_i;

  spi_master_tx_shifter dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clk_div_i (clk_div_i),
    .en_i      (en_i),
    .tx_len_i  (tx_len_i),
    .quad_i    (quad_i),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .spi_clk_o (spi_clk_o),
    .sdo_o     (sdo_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Monitor: the bit sent on each SCK rise is the value held during the preceding low phase.
  always @(negedge clk_i) begin
    cyc++;
    if (spi_clk_o && !prev_sck) begin
      obs.push_back(prev_sdo);
      rises++;
      if (exp_period != 0 && rises > 1 && cyc - last_rise != exp_period) irregular++;
      last_rise = cyc;
    end
    if (ready_o) readies++;
    if (ready_o && !valid_i) bad_ready++;
    if (ready_o && valid_i && fifo.size() > 0) fifo.delete(0);
    if (done_o) begin
      dones++;
      done_cyc = cyc;
      rises_at_done = rises;
    end
    if (!quad_eff && sdo_o[3:1] != 3'b0) hi13++;
    if (en_i) start_cyc = cyc;
    prev_sck = spi_clk_o;
    prev_sdo = sdo_o;
  end

  // FIFO driver: word k is offered only once k words' worth of bits are out, then after hold[k] idle cycles.
  always @(posedge clk_i) begin
    #1;
    if (readies != seen_readies) begin
      hold_cnt = 0;
      seen_readies = readies;
    end
    if (fifo.size() > 0 && rises >= readies * ppw && hold_cnt < hold[readies % 8]) hold_cnt++;
    valid_i = fifo.size() > 0 && rises >= readies * ppw && hold_cnt >= hold[readies % 8];
    data_i = fifo.size() > 0 ? fifo[0] : 32'h0;
    if (scr) quad_i = 1'($urandom);
  end

  task automatic start_xfer(input int div, input int len, input bit quad);
    int nw;
    @(negedge clk_i);
    #2;
    nw = (len + 31) / 32;
    quad_eff = quad && QUAD_BUILD;
    ppw = quad_eff ? 8 : 32;
    fifo = {};
    for (int i = 0; i < nw; i++) fifo.push_back(words_in[i]);
    obs = {};
    rises = 0; readies = 0; dones = 0; bad_ready = 0; hi13 = 0; irregular = 0;
    hold_cnt = 0; seen_readies = 0; rises_at_done = 0; done_cyc = 0;
    exp_period = 2 * (div + 1);
    for (int i = 1; i < nw; i++) if (hold[i] != 0) exp_period = 0;
    @(posedge clk_i);
    #1;
    clk_div_i = 8'(div);
    tx_len_i = 16'(len);
    quad_i = quad;
    en_i = 1;
    @(posedge clk_i);
    #1;
    en_i = 0;
  endtask

  task automatic run_xfer(input int div, input int len, input bit quad, input bit scramble);
    int np, nw, budget, bp, off, rem;
    bit eq;
    logic [31:0] w;
    logic [3:0] e;
    eq = quad && QUAD_BUILD;
    np = eq ? (len + 3) / 4 : len;
    nw = (len + 31) / 32;
    budget = np * 2 * (div + 1) + 8 * nw + 40;
    for (int i = 0; i < nw; i++) budget += hold[i];
    start_xfer(div, len, quad);
    check("busy_start", {31'b0, busy_o}, 1);
    scr = scramble;
    for (int i = 0; i < budget && dones == 0; i++) @(negedge clk_i);
    scr = 0;
    repeat (3) @(negedge clk_i);
    #2;
    check("rises", rises, np);
    check("ready_pulses", readies, nw);
    check("done_pulses", dones, 1);
    check("rises_at_done", rises_at_done, np);
    check("ready_without_valid", bad_ready, 0);
    check("sdo_hi_lanes", hi13, 0);
    check("busy_idle", {31'b0, busy_o}, 0);
    if (exp_period != 0) check("sck_contiguous", irregular, 0);
    if (len == 0) check("len0_latency", done_cyc - start_cyc, 1);
    for (int k = 0; k < np; k++) begin
      bp = eq ? 4 * k : k;
      w = words_in[bp / 32];
      off = bp % 32;
      if (eq) begin
        rem = len - 4 * k;
        e = 4'(w >> (28 - off));
        if (rem < 4) e = e & 4'(4'hF << (4 - rem));
      end else e = {3'b0, w[31 - off]};
      check($sformatf("sdo[%0d]", k), k < obs.size() ? {28'b0, obs[k]} : 32'hFFFF_FFFF, {28'b0, e});
    end
  endtask

  initial begin
    hold = '{default: 0};
    #3;
    check("reset_outs", {24'b0, spi_clk_o, sdo_o, ready_o, busy_o, done_o}, 0);
    @(negedge clk_i);
    rst_ni = 1;
    words_in[0] = 32'hA500_0000;
    run_xfer(0, 8, 0, 0);
    words_in[0] = 32'hDEAD_BEEF;
    words_in[1] = 32'h1234_5678;
    run_xfer(0, 64, 0, 0);
    words_in[0] = 32'h0123_ABCD;
    run_xfer(0, 32, 1, 0);
    words_in[0] = 32'h5A5A_C3C3;
    words_in[1] = 32'h9600_0000;
    hold[1] = 10;
    run_xfer(0, 40, 0, 0);
    hold[1] = 0;
    run_xfer(2, 0, 0, 0);
    words_in[0] = 32'hFFFF_FFFF;
    run_xfer(1, 10, 1, 0);
    words_in[0] = 32'hA500_0000;
    run_xfer(0, 8, 1, 0);
    words_in[0] = 32'hCAFE_F00D;
    start_xfer(1, 32, 0);
    for (int i = 0; i < 400 && !(rises >= 3 && spi_clk_o); i++) @(negedge clk_i);
    check("rst_mid_shift", {31'b0, spi_clk_o}, 1);
    #2 rst_ni = 0;
    #1 check("rst_async_outs", {24'b0, spi_clk_o, sdo_o, ready_o, busy_o, done_o}, 0);
    repeat (3) @(negedge clk_i);
    #2 rst_ni = 1;
    fifo = {};
    repeat (5) @(negedge clk_i);
    #2 check("rst_no_done", dones, 0);
    words_in[0] = 32'hA500_0000;
    run_xfer(0, 8, 0, 0);
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 8; i++) begin
        words_in[i] = $urandom;
        hold[i] = $urandom_range(0, 3) == 0 ? $urandom_range(1, 12) : 0;
      end
      run_xfer($urandom_range(0, 3), $urandom_range(1, 100), 1'($urandom_range(0, 1)), 1);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/spi_master_tx_shifter.md
SPI_MASTER_TX_SHIFTER -- requirements
Module: spi_master_tx_shifter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width popped from the TX FIFO; multiple of 4, at least 8.
REQ-002 Parameter LEN_WIDTH, default 16, width of the transfer bit-count.
REQ-003 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 clk_div_i  input  8  SPI half-period in clk_i cycles, minus 1.
REQ-006 en_i  input  1  start pulse; sampled only in IDLE.
REQ-007 tx_len_i  input  LEN_WIDTH  number of bits to send; sampled with en_i.
REQ-008 quad_i  input  1  1 = quad mode (4 bits per SCK), 0 = single mode.
REQ-009 data_i  input  DATA_WIDTH  word from the TX FIFO.
REQ-010 valid_i  input  1  FIFO word available.
REQ-011 ready_o  output  1  pop strobe to the FIFO.
REQ-012 spi_clk_o  output  1  SPI clock, CPOL=0.
REQ-013 sdo_o  output  4  serial data; single mode uses bit 0 only, bits 3:1 held 0.
REQ-014 busy_o  output  1  high from start acceptance until done.
REQ-015 done_o  output  1  one-cycle pulse when the last bit's SCK high phase ends.

Function
REQ-016 FSM states: IDLE, LOAD, SHIFT, WAIT_DATA, DONE.
REQ-017 IDLE->LOAD on en_i=1 with tx_len_i!=0; en_i with tx_len_i=0 produces a done_o pulse on the next cycle and no SCK edges.
REQ-018 LOAD: if valid_i=1, capture data_i into the shift register, assert ready_o for exactly that cycle, then go to SHIFT; otherwise go to WAIT_DATA.
REQ-019 WAIT_DATA: spi_clk_o held 0 and the divider counter held at 0; on valid_i=1 behave as LOAD.
REQ-020 SHIFT: data is MSB-first; sdo_o is valid for a full SCK low phase before each rising edge, and the shift happens on the falling edge.
REQ-021 Each SCK phase lasts clk_div_i+1 clk_i cycles; clk_div_i is sampled at start and held for the transfer.
REQ-022 The bit counter decrements by 1 in single mode or by 4 in quad mode per SCK period; it saturates at 0.
REQ-023 In quad mode a remaining count below 4 sends one final nibble; unused low lanes drive 0.
REQ-024 Word boundary: after DATA_WIDTH bits, if bits remain, the FSM returns to LOAD at the falling edge; with valid_i=1 it adds no extra SCK cycle.
REQ-025 On the final falling edge, go to DONE; DONE pulses done_o for one cycle, then returns to IDLE.
REQ-026 ready_o is never asserted outside LOAD/WAIT_DATA and never on a cycle with valid_i=0.
REQ-027 quad_i is sampled at start; changing it mid-transfer has no effect.

Reset
REQ-028 On reset assertion: state=IDLE; spi_clk_o, sdo_o, ready_o, busy_o, done_o, counters and shift register all 0, independent of clk_i.
REQ-029 Reset mid-transfer aborts immediately; no done_o pulse; the next start after release behaves as from power-up.

Configuration
REQ-030 Macro SPI_MASTER_TX_QUAD_EN: when defined, quad mode is supported as specified above.
REQ-031 When SPI_MASTER_TX_QUAD_EN is undefined, quad_i is ignored, sdo_o[3:1] is tied to 0, and the nibble logic is removed.

Structure
REQ-032 Package spi_master_pkg holds the FSM state typedef, a SPI_DIV_WIDTH=8 constant, and SPI_LANES=4.
REQ-033 Sub-module spi_master_clkgen generates spi_clk_o and one-cycle rise/fall strobes from clk_div_i with an enable input; the FSM consumes these strobes.

Verification
REQ-034 clk_div_i=0, single, tx_len_i=8, data_i=0xA5000000 already valid -> 8 SCK periods of 2 clk_i each, sdo_o[0]=1,0,1,0,0,1,0,1, one ready_o pulse, one done_o pulse.
REQ-035 Single, tx_len_i=64, two words 0xDEADBEEF then 0x12345678 both valid -> 64 contiguous SCK periods with no gap at the word boundary, and two ready_o pulses.
REQ-036 Quad, tx_len_i=32, data_i=0x0123ABCD -> 8 SCK periods with sdo_o=0,1,2,3,A,B,C,D.
REQ-037 Single, tx_len_i=40, valid_i held low for 10 cycles at the word boundary -> spi_clk_o stays 0 and the FSM holds in WAIT_DATA, then sends the remaining 8 bits; total 40 rising edges.
REQ-038 rst_ni pulsed low mid-SHIFT -> all outputs 0 within the same cycle, no done_o pulse; a new 8-bit transfer afterwards passes REQ-034.
REQ-039 Build without SPI_MASTER_TX_QUAD_EN, quad_i=1, tx_len_i=8 -> single-mode behaviour and sdo_o[3:1]=0 throughout.
